ch_est_cntrl_unit: RTL and testbench

- Control unit of the NB-IoT channel-estimation block.
- Sequences the NRS pilot processing for one subframe: it reads demapped pilots and generated NRS, multiplies them, stores slot-1 products and averages in slot-2 products.
- It then drives the mux selects and register enables of the frequency-interpolation datapath, and flags valid estimates to the equalizer.

---
 rtl/ch_est_cntrl_unit.sv | 225 ++++++++++++++++++++++
 tb/tb_ch_est_cntrl_unit.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/ch_est_cntrl_unit.sv
// ch_est_cntrl_unit
//   Control unit of the NB-IoT channel-estimation block. For each subframe it
//   runs four 2-cycle pilot passes. Each pass reads the demapped pilots and the
//   generated NRS, and writes the products: passes 0/1 go to the product
//   memory and passes 2/3 to the average memory. It then steps the
//   frequency-interpolation datapath through a group-specific select/enable
//   sequence chosen by v_shift mod 3.
//
// Ports
//   clk, rst                  clock (rising edge), synchronous active-low reset
//   demap_ready, NRS_gen_ready  upstream data available; both must be high to
//                             start a pass
//   v_shift[2:0]              cell frequency shift; only v_shift mod 3 is used
//   col, nrs_index_addr, demap_read, rd_addr_nrs, est_ack_nrs
//                             pilot read side
//   addr_mem, mult_mem_en, avg_mem_en
//                             product/average memory side
//   est_ack_demap, valid_eqlz, en_reg_E/2E/5E, s1a/s1b/s2a/s2b, s_h1/s_h2, s_est
//                             interpolation datapath control
//   All outputs except s_est are registered.
module ch_est_cntrl_unit #(
    parameter int NRS_ADDR = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                demap_ready,
    input  logic                NRS_gen_ready,
    input  logic [2:0]          v_shift,
    output logic [3:0]          col,
    output logic [1:0]          nrs_index_addr,
    output logic                demap_read,
    output logic                est_ack_demap,
    output logic                est_ack_nrs,
    output logic [NRS_ADDR-1:0] rd_addr_nrs,
    output logic                valid_eqlz,
    output logic [1:0]          addr_mem,
    output logic                mult_mem_en,
    output logic                avg_mem_en,
    output logic                en_reg_E,
    output logic                en_reg_2E,
    output logic                en_reg_5E,
    output logic [2:0]          s1a,
    output logic [2:0]          s1b,
    output logic [2:0]          s2a,
    output logic [2:0]          s2b,
    output logic [1:0]          s_h1,
    output logic [1:0]          s_h2,
    output logic                s_est
);

    typedef enum logic [1:0] {IDLE, MULT_STORE, MULT_ADD} state_t;

    // Sequencer word: {s1a, s1b, s2a, s2b, s_h1, s_h2, valid, en_E, en_2E, en_5E}
    localparam logic [19:0] SEQ_DEF = {3'd7, 3'd7, 3'd7, 3'd7, 2'd0, 2'd0, 4'b0000};

    state_t              state_q, state_d;
    logic                cyc_q, cyc_d;          // 0: first pass cycle, 1: second
    logic [1:0]          pass_q, pass_d;
    logic [2:0]          p_q, p_d;
    logic                act_q, act_d;          // sequencer running
    logic [3:0]          j_q, j_d;
    logic [3:0]          col_q, col_d;
    logic [1:0]          addr_q, addr_d;
    logic [NRS_ADDR-1:0] rd_q, rd_d;
    logic                rd_en_q, rd_en_d;
    logic                mult_q, mult_d;
    logic                avg_q, avg_d;
    logic [19:0]         seq_q, seq_d;
    logic [1:0]          grp;
    logic [3:0]          last_j;

    always_comb begin
        case (v_shift)
            3'd0, 3'd3, 3'd6: grp = 2'd0;
            3'd1, 3'd4, 3'd7: grp = 2'd1;
            default:          grp = 2'd2;
        endcase
        case (grp)
            2'd0:    last_j = 4'd6;
            2'd1:    last_j = 4'd7;
            default: last_j = 4'd8;
        endcase
    end

    assign s_est = (grp == 2'd1);

    function automatic logic [19:0] seq_tbl(input logic [1:0] g, input logic [3:0] j);
        case ({g, j})
            // group A
            6'h00: seq_tbl = {3'd0, 3'd0, 3'd0, 3'd0, 2'd0, 2'd0, 4'b1000};
            6'h01: seq_tbl = {3'd1, 3'd0, 3'd1, 3'd1, 2'd0, 2'd0, 4'b1100};
            6'h02: seq_tbl = {3'd3, 3'd1, 3'd3, 3'd0, 2'd1, 2'd1, 4'b1010};
            6'h03: seq_tbl = {3'd3, 3'd1, 3'd3, 3'd3, 2'd3, 2'd0, 4'b1000};
            6'h04: seq_tbl = {3'd3, 3'd3, 3'd2, 3'd3, 2'd2, 2'd0, 4'b1000};
            6'h05: seq_tbl = {3'd2, 3'd2, 3'd2, 3'd2, 2'd3, 2'd3, 4'b1001};
            6'h06: seq_tbl = {3'd7, 3'd7, 3'd7, 3'd7, 2'd1, 2'd2, 4'b0000};
            // group B
            6'h10: seq_tbl = {3'd7, 3'd7, 3'd6, 3'd6, 2'd0, 2'd0, 4'b0000};
            6'h11: seq_tbl = {3'd7, 3'd7, 3'd4, 3'd4, 2'd0, 2'd0, 4'b1010};
            6'h12: seq_tbl = {3'd6, 3'd6, 3'd0, 3'd0, 2'd1, 2'd1, 4'b1000};
            6'h13: seq_tbl = {3'd3, 3'd1, 3'd0, 3'd0, 2'd1, 2'd2, 4'b1000};
            6'h14: seq_tbl = {3'd0, 3'd0, 3'd3, 3'd0, 2'd0, 2'd2, 4'b1000};
            6'h15: seq_tbl = {3'd3, 3'd3, 3'd3, 3'd3, 2'd1, 2'd3, 4'b1100};
            6'h16: seq_tbl = {3'd7, 3'd7, 3'd2, 3'd2, 2'd3, 2'd2, 4'b1000};
            6'h17: seq_tbl = {3'd7, 3'd7, 3'd7, 3'd7, 2'd2, 2'd0, 4'b0000};
            // group C
            6'h20: seq_tbl = {3'd7, 3'd7, 3'd1, 3'd4, 2'd0, 2'd0, 4'b0000};
            6'h21: seq_tbl = {3'd4, 3'd0, 3'd6, 3'd6, 2'd0, 2'd0, 4'b0001};
            6'h22: seq_tbl = {3'd5, 3'd4, 3'd4, 3'd4, 2'd0, 2'd0, 4'b1110};
            6'h23: seq_tbl = {3'd5, 3'd4, 3'd0, 3'd0, 2'd3, 2'd0, 4'b1000};
            6'h24: seq_tbl = {3'd6, 3'd6, 3'd0, 3'd0, 2'd0, 2'd0, 4'b1000};
            6'h25: seq_tbl = {3'd3, 3'd1, 3'd3, 3'd0, 2'd3, 2'd1, 4'b1000};
            6'h26: seq_tbl = {3'd3, 3'd1, 3'd3, 3'd3, 2'd3, 2'd0, 4'b1000};
            6'h27: seq_tbl = {3'd3, 3'd3, 3'd7, 3'd7, 2'd2, 2'd2, 4'b1000};
            6'h28: seq_tbl = {3'd7, 3'd7, 3'd7, 3'd7, 2'd1, 2'd3, 4'b0000};
            default: seq_tbl = SEQ_DEF;
        endcase
    endfunction

    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        pass_d  = pass_q;
        p_d     = p_q;
        act_d   = 1'b0;
        j_d     = 4'd0;
        col_d   = col_q;
        addr_d  = addr_q;
        rd_d    = rd_q;
        rd_en_d = 1'b0;
        mult_d  = 1'b0;
        avg_d   = 1'b0;
        seq_d   = SEQ_DEF;

        case (state_q)
            IDLE: begin
                if (demap_ready && NRS_gen_ready) begin
                    state_d = (pass_q < 2'd2) ? MULT_STORE : MULT_ADD;
                    cyc_d   = 1'b0;
                end
            end
            default: begin
                if (!cyc_q) begin
                    cyc_d = 1'b1;
                end else begin
                    state_d = IDLE;
                    cyc_d   = 1'b0;
                    pass_d  = pass_q + 2'd1;
                end
            end
        endcase

        // Pass outputs are computed from the next state so they line up with
        // the cycles the FSM spends in MULT_STORE / MULT_ADD.
        if (state_d != IDLE) begin
            rd_en_d = 1'b1;
            addr_d  = p_q[1:0];
            rd_d    = NRS_ADDR'({p_q, 1'b0});
            p_d     = p_q + 3'd1;
            case (pass_q)
                2'd0:    col_d = 4'd5;
                2'd1:    col_d = 4'd6;
                2'd2:    col_d = 4'd12;
                default: col_d = 4'd13;
            endcase
            mult_d = cyc_d && (state_d == MULT_STORE);
            avg_d  = cyc_d && (state_d == MULT_ADD);
        end

        // Step 0 lands on the second cycle of pass 3; the FSM does not wait
        // for the sequencer.
        if ((state_d != IDLE) && cyc_d && (pass_q == 2'd3)) begin
            act_d = 1'b1;
            j_d   = 4'd0;
        end else if (act_q && (j_q != last_j)) begin
            act_d = 1'b1;
            j_d   = j_q + 4'd1;
        end
        if (act_d) seq_d = seq_tbl(grp, j_d);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cyc_q   <= 1'b0;
            pass_q  <= 2'd0;
            p_q     <= 3'd0;
            act_q   <= 1'b0;
            j_q     <= 4'd0;
            col_q   <= 4'd0;
            addr_q  <= 2'd0;
            rd_q    <= '0;
            rd_en_q <= 1'b0;
            mult_q  <= 1'b0;
            avg_q   <= 1'b0;
            seq_q   <= SEQ_DEF;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            pass_q  <= pass_d;
            p_q     <= p_d;
            act_q   <= act_d;
            j_q     <= j_d;
            col_q   <= col_d;
            addr_q  <= addr_d;
            rd_q    <= rd_d;
            rd_en_q <= rd_en_d;
            mult_q  <= mult_d;
            avg_q   <= avg_d;
            seq_q   <= seq_d;
        end
    end

    assign col            = col_q;
    assign nrs_index_addr = addr_q;
    assign addr_mem       = addr_q;
    assign rd_addr_nrs    = rd_q;
    assign demap_read     = rd_en_q;
    assign est_ack_nrs    = rd_en_q;
    assign mult_mem_en    = mult_q;
    assign avg_mem_en     = avg_q;
    assign est_ack_demap  = act_q;
    assign {s1a, s1b, s2a, s2b, s_h1, s_h2, valid_eqlz, en_reg_E, en_reg_2E, en_reg_5E} = seq_q;

endmodule

// File: tb/tb_ch_est_cntrl_unit.sv
module tb_ch_est_cntrl_unit;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       demap_ready = 1'b0;
    logic       NRS_gen_ready = 1'b0;
    logic [2:0] v_shift = 3'd0;
    logic [3:0] col;
    logic [1:0] nrs_index_addr, addr_mem, s_h1, s_h2;
    logic       demap_read, est_ack_demap, est_ack_nrs, valid_eqlz;
    logic       mult_mem_en, avg_mem_en, en_reg_E, en_reg_2E, en_reg_5E, s_est;
    logic [3:0] rd_addr_nrs;
    logic [2:0] s1a, s1b, s2a, s2b;

    ch_est_cntrl_unit #(.NRS_ADDR(4)) dut (
        .clk(clk), .rst(rst), .demap_ready(demap_ready), .NRS_gen_ready(NRS_gen_ready),
        .v_shift(v_shift), .col(col), .nrs_index_addr(nrs_index_addr),
        .demap_read(demap_read), .est_ack_demap(est_ack_demap), .est_ack_nrs(est_ack_nrs),
        .rd_addr_nrs(rd_addr_nrs), .valid_eqlz(valid_eqlz), .addr_mem(addr_mem),
        .mult_mem_en(mult_mem_en), .avg_mem_en(avg_mem_en), .en_reg_E(en_reg_E),
        .en_reg_2E(en_reg_2E), .en_reg_5E(en_reg_5E), .s1a(s1a), .s1b(s1b),
        .s2a(s2a), .s2b(s2b), .s_h1(s_h1), .s_h2(s_h2), .s_est(s_est)
    );

    always #5 clk = ~clk;

    // Step tables, one row per group (A, B, C), copied from the step lists.
    int S1A [3][9] = '{'{0,1,3,3,3,2,7,0,0}, '{7,7,6,3,0,3,7,7,0}, '{7,4,5,5,6,3,3,3,7}};
    int S1B [3][9] = '{'{0,0,1,1,3,2,7,0,0}, '{7,7,6,1,0,3,7,7,0}, '{7,0,4,4,6,1,1,3,7}};
    int S2A [3][9] = '{'{0,1,3,3,2,2,7,0,0}, '{6,4,0,0,3,3,2,7,0}, '{1,6,4,0,0,3,3,7,7}};
    int S2B [3][9] = '{'{0,1,0,3,3,2,7,0,0}, '{6,4,0,0,0,3,2,7,0}, '{4,6,4,0,0,0,3,7,7}};
    int SH1 [3][9] = '{'{0,0,1,3,2,3,1,0,0}, '{0,0,1,1,0,1,3,2,0}, '{0,0,0,3,0,3,3,2,1}};
    int SH2 [3][9] = '{'{0,0,1,0,0,3,2,0,0}, '{0,0,1,2,2,3,2,0,0}, '{0,0,0,0,0,1,0,2,3}};
    int XLEN[3] = '{7, 8, 9};
    int VLO [3] = '{0, 1, 2};
    int VHI [3] = '{5, 6, 7};
    int EJ  [3] = '{1, 5, 2};
    int E2J [3] = '{2, 1, 2};
    int E5J [3] = '{5, -1, 1};
    int COLS[4] = '{5, 6, 12, 13};

    logic [37:0] sb_q[$];
    int          total = 0;
    int          bad = 0;
    string       tag = "init";
    int          cycle = 0;

    // Bench-side expectation state
    logic [3:0] col_e = 4'd0;
    logic [1:0] addr_e = 2'd0;
    logic [3:0] rd_e = 4'd0;
    int         seq_j = -1;
    int         grp_e = 0;

    // Drive one cycle of inputs, push the expected post-edge output vector,
    // clock, then pop and compare. pc = pass cycle (0 none, 1 first, 2 second)
    // the DUT is expected to be in after this edge; k = pass, p = pilot count.
    task automatic tick(input logic dr, input logic nr, input int pc, input int k, input int p);
        logic [37:0] e, a;
        logic [2:0]  xa, xb, xc, xd;
        logic [1:0]  h1, h2;
        logic        vld, ee, e2, e5, dm, mm, am, sa;
        demap_ready   = dr;
        NRS_gen_ready = nr;
        if (!rst) begin
            col_e = 4'd0; addr_e = 2'd0; rd_e = 4'd0; seq_j = -1; pc = 0;
        end else begin
            if (pc != 0) begin
                col_e  = 4'(COLS[k]);
                addr_e = 2'(p % 4);
                rd_e   = 4'((2 * p) % 16);
            end
            if (seq_j >= 0) begin
                seq_j++;
                if (seq_j == XLEN[grp_e]) seq_j = -1;
            end
            if (pc == 2 && k == 3) seq_j = 0;
        end
        dm = (pc != 0);
        mm = (pc == 2) && (k < 2);
        am = (pc == 2) && (k >= 2);
        sa = (seq_j >= 0);
        if (sa) begin
            xa = 3'(S1A[grp_e][seq_j]); xb = 3'(S1B[grp_e][seq_j]);
            xc = 3'(S2A[grp_e][seq_j]); xd = 3'(S2B[grp_e][seq_j]);
            h1 = 2'(SH1[grp_e][seq_j]); h2 = 2'(SH2[grp_e][seq_j]);
            vld = (seq_j >= VLO[grp_e]) && (seq_j <= VHI[grp_e]);
            ee = (seq_j == EJ[grp_e]); e2 = (seq_j == E2J[grp_e]); e5 = (seq_j == E5J[grp_e]);
        end else begin
            xa = 3'd7; xb = 3'd7; xc = 3'd7; xd = 3'd7; h1 = 2'd0; h2 = 2'd0;
            vld = 1'b0; ee = 1'b0; e2 = 1'b0; e5 = 1'b0;
        end
        e = {col_e, addr_e, addr_e, rd_e, dm, dm, mm, am, sa, vld, ee, e2, e5,
             xa, xb, xc, xd, h1, h2, (v_shift % 3 == 1)};
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        cycle++;
        a = {col, nrs_index_addr, addr_mem, rd_addr_nrs, demap_read, est_ack_nrs,
             mult_mem_en, avg_mem_en, est_ack_demap, valid_eqlz, en_reg_E, en_reg_2E,
             en_reg_5E, s1a, s1b, s2a, s2b, s_h1, s_h2, s_est};
        e = sb_q.pop_front();
        total++;
        assert (a === e) else begin
            bad++;
            $error("FAIL %s cyc=%0d got=%h exp=%h", tag, cycle, a, e);
        end
    endtask

    // One subframe: four passes separated by g idle cycles, readies pulsed
    // (hold=0) or held high (hold=1, g=1), then run out the sequencer.
    // abort=1 applies reset at the fourth sequencer cycle.
    task automatic subframe(input int vs, input int g, input logic hold, input bit abort);
        int n;
        v_shift = 3'(vs);
        grp_e   = vs % 3;
        for (int k = 0; k < 4; k++) begin
            tick(1'b1, 1'b1, 1, k, 2 * k);
            tick(hold, hold, 2, k, 2 * k + 1);
            if (k < 3) for (int i = 0; i < g; i++) tick(hold, hold, 0, 0, 0);
        end
        n = 0;
        while (seq_j >= 0 && n < 20) begin
            if (abort && n == 3) begin
                rst = 1'b0;
                tick(1'b0, 1'b0, 0, 0, 0);
                rst = 1'b1;
            end else begin
                tick(1'b0, 1'b0, 0, 0, 0);
            end
            n++;
        end
    endtask

    initial begin
        tag = "reset";
        rst = 1'b0;
        repeat (3) tick(1'b1, 1'b1, 0, 0, 0);
        rst = 1'b1;

        tag = "one_ready";
        for (int vs = 0; vs < 6; vs++) begin
            v_shift = 3'(vs);
            tick(1'b1, 1'b0, 0, 0, 0);
            tick(1'b0, 1'b1, 0, 0, 0);
        end

        tag = "sf_gap2_vs0";
        subframe(0, 2, 1'b0, 1'b0);

        tag = "sf_hold_vs0";
        subframe(0, 1, 1'b1, 1'b0);

        // Back-to-back subframes: the first pass of each starts from the
        // cycle right after the previous sequence's last step.
        tag = "b2b_vs3"; subframe(3, 1, 1'b1, 1'b0);
        tag = "b2b_vs1"; subframe(1, 1, 1'b1, 1'b0);
        tag = "b2b_vs4"; subframe(4, 1, 1'b0, 1'b0);
        tag = "b2b_vs2"; subframe(2, 1, 1'b1, 1'b0);
        tag = "b2b_vs5"; subframe(5, 2, 1'b0, 1'b0);

        tag = "rst_mid_pass";
        v_shift = 3'd1;
        tick(1'b1, 1'b1, 1, 0, 0);
        rst = 1'b0;
        tick(1'b0, 1'b0, 0, 0, 0);
        rst = 1'b1;
        tick(1'b0, 1'b0, 0, 0, 0);
        tag = "after_rst_pass";
        subframe(1, 1, 1'b0, 1'b0);

        tag = "rst_mid_seq";
        subframe(2, 1, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 0, 0, 0);
        tag = "after_rst_seq";
        subframe(0, 1, 1'b1, 1'b0);
        tick(1'b0, 1'b0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
